design1_wrapper: RTL and testbench

DESIGN1_WRAPPER -- requirements
Module: design1_wrapper

---
 rtl/design1_wrapper.sv | 260 ++++++++++++++++++++++++++
 tb/tb_design1_wrapper.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/design1_wrapper.sv
// Bus-mapped input/output word buffers plus a small task engine:
// task 1 writes a one-hot argmax over 250 words, task 7 writes a 256-word sum.
module design1_wrapper #(
  parameter int IN_WORDS  = 512,
  parameter int OUT_WORDS = 512
) (
  input  logic        pl_clk0,
  input  logic        pl_resetn0,
  input  logic [16:0] bus_addr,
  input  logic        bus_wr_en,
  input  logic [31:0] bus_wr_data,
  input  logic        bus_rd_en,
  output logic [31:0] bus_rd_data,
  output logic        bus_rd_valid,
  output logic        bus_resp
);
  localparam int IN_AW  = $clog2(IN_WORDS);
  localparam int OUT_AW = $clog2(OUT_WORDS);
  localparam logic [8:0] T1_LEN = 9'd250;
  localparam logic [8:0] T7_LEN = 9'd256;
  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_IN  = 2'd1;
  localparam logic [1:0] SEL_OUT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]  r_task;
  logic        r_tv_in;
  logic        r_tv_out;
  logic [8:0]  r_idx;
  logic [8:0]  r_k;
  logic [31:0] r_acc;
  logic [31:0] r_max;
  logic [1:0]  r_rd_sel;
  logic [31:0] r_rd_val;

  logic [31:0] r_in_mem  [IN_WORDS];
  logic [31:0] r_out_mem [OUT_WORDS];
  logic [31:0] r_in_qa;
  logic [31:0] r_in_qb;
  logic [31:0] r_out_q;

  logic              w_busy;
  logic              w_is_t1;
  logic              w_supported;
  logic [8:0]        w_scan_len;
  logic              w_sel_in;
  logic              w_sel_out;
  logic              w_sel_reg;
  logic              w_wr_err;
  logic              w_in_we;
  logic              w_task_we;
  logic              w_start;
  logic              w_rd_err;
  logic [1:0]        w_rd_sel;
  logic [31:0]       w_rd_val;
  logic              w_eng_we;
  logic [OUT_AW-1:0] w_eng_waddr;
  logic [31:0]       w_eng_wdata;
  logic              w_unused_addr;

  assign w_unused_addr = ^bus_addr[1:0];
  assign w_busy        = (r_state != S_IDLE);
  assign w_is_t1       = (r_task == 8'd1);
  assign w_supported   = w_is_t1 || (r_task == 8'd7);
  assign w_scan_len    = w_is_t1 ? T1_LEN : T7_LEN;
  assign w_sel_in      = (bus_addr[16:11] == 6'd0);
  assign w_sel_out     = (bus_addr[16:11] == 6'd1);
  assign w_sel_reg     = bus_addr[16] && (bus_addr[15:5] == 11'd0) && (bus_addr[4:2] <= 3'd4);

  // Write decode: busy-time input/task writes are errors, TV_IN_READY writes never are.
  always_comb begin
    w_wr_err  = 1'b0;
    w_in_we   = 1'b0;
    w_task_we = 1'b0;
    w_start   = 1'b0;
    if (!bus_wr_en) begin
      w_wr_err = 1'b0;
    end else if (w_sel_in) begin
      w_in_we  = !w_busy;
      w_wr_err = w_busy;
    end else if (w_sel_reg) begin
      case (bus_addr[4:2])
        3'd2: begin
          w_task_we = !w_busy;
          w_wr_err  = w_busy;
        end
        3'd3:    w_start  = !w_busy && bus_wr_data[0];
        default: w_wr_err = 1'b1;
      endcase
    end else begin
      w_wr_err = 1'b1;
    end
  end

  always_comb begin
    w_rd_err = 1'b0;
    w_rd_sel = SEL_REG;
    w_rd_val = 32'd0;
    if (w_sel_in) begin
      w_rd_sel = SEL_IN;
    end else if (w_sel_out) begin
      w_rd_sel = SEL_OUT;
    end else if (w_sel_reg) begin
      case (bus_addr[4:2])
        3'd0:    w_rd_val = 32'd1;
        3'd1:    w_rd_val = 32'h0000_0082;
        3'd2:    w_rd_val = {24'd0, r_task};
        3'd3:    w_rd_val = {31'd0, r_tv_in};
        3'd4:    w_rd_val = {31'd0, r_tv_out};
        default: w_rd_err = 1'b1;
      endcase
    end else begin
      w_rd_err = 1'b1;
    end
  end

  always_ff @(posedge pl_clk0 or negedge pl_resetn0) begin
    if (!pl_resetn0) begin
      bus_rd_valid <= 1'b0;
      bus_resp     <= 1'b0;
      r_rd_sel     <= SEL_REG;
      r_rd_val     <= 32'd0;
    end else begin
      bus_rd_valid <= bus_rd_en;
      bus_resp     <= (bus_rd_en && w_rd_err) || (bus_wr_en && w_wr_err);
      r_rd_sel     <= bus_rd_en ? w_rd_sel : SEL_REG;
      r_rd_val     <= bus_rd_en ? w_rd_val : 32'd0;
    end
  end

  // RAM read registers feed the data mux directly so RAM reads keep 1-cycle latency.
  always_comb begin
    case (r_rd_sel)
      SEL_IN:  bus_rd_data = r_in_qa;
      SEL_OUT: bus_rd_data = r_out_q;
      default: bus_rd_data = r_rd_val;
    endcase
  end

  always_ff @(posedge pl_clk0 or negedge pl_resetn0) begin
    if (!pl_resetn0) begin
      r_task   <= 8'd0;
      r_tv_in  <= 1'b0;
      r_tv_out <= 1'b0;
    end else begin
      if (w_task_we) begin
        r_task <= bus_wr_data[7:0];
      end
      if (w_start) begin
        r_tv_in  <= 1'b1;
        r_tv_out <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_tv_in  <= 1'b0;
        r_tv_out <= 1'b1;
      end
    end
  end

  always_ff @(posedge pl_clk0 or negedge pl_resetn0) begin
    if (!pl_resetn0) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_eng_we    = 1'b0;
    w_eng_waddr = {OUT_AW{1'b0}};
    w_eng_wdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = w_supported ? S_SCAN : S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SCAN: begin
        if (w_is_t1 && (r_idx < T1_LEN)) begin
          w_eng_we    = 1'b1;
          w_eng_waddr = OUT_AW'(r_idx);
        end else begin
          w_eng_we = 1'b0;
        end
        if (r_idx == w_scan_len) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_SCAN;
        end
      end
      S_WRITE: begin
        w_eng_we = 1'b1;
        w_next   = S_DONE;
        if (w_is_t1) begin
          w_eng_waddr = OUT_AW'(r_k);
          w_eng_wdata = 32'd1;
        end else begin
          w_eng_waddr = {OUT_AW{1'b0}};
          w_eng_wdata = r_acc;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so r_idx=j carries input word j-1.
  always_ff @(posedge pl_clk0 or negedge pl_resetn0) begin
    if (!pl_resetn0) begin
      r_idx <= 9'd0;
      r_k   <= 9'd0;
      r_acc <= 32'd0;
      r_max <= 32'd0;
    end else if (w_start) begin
      r_idx <= 9'd0;
      r_k   <= 9'd0;
      r_acc <= 32'd0;
      r_max <= 32'd0;
    end else if (r_state == S_SCAN) begin
      r_idx <= r_idx + 9'd1;
      if (r_idx != 9'd0) begin
        r_acc <= r_acc + r_in_qb;
        if ((r_idx == 9'd1) || (r_in_qb > r_max)) begin
          r_max <= r_in_qb;
          r_k   <= r_idx - 9'd1;
        end
      end
    end
  end

  always_ff @(posedge pl_clk0) begin
    if (w_in_we) begin
      r_in_mem[bus_addr[IN_AW+1:2]] <= bus_wr_data;
    end
    r_in_qa <= r_in_mem[bus_addr[IN_AW+1:2]];
  end

  always_ff @(posedge pl_clk0) begin
    r_in_qb <= r_in_mem[IN_AW'(r_idx)];
  end

  always_ff @(posedge pl_clk0) begin
    if (w_eng_we) begin
      r_out_mem[w_eng_waddr] <= w_eng_wdata;
    end
    r_out_q <= r_out_mem[bus_addr[OUT_AW+1:2]];
  end

endmodule

// File: tb/tb_design1_wrapper.sv
// Directed bench for design1_wrapper: register map, task 1/7 results, busy and reset behaviour.
module tb_design1_wrapper;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        resp;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  design1_wrapper #(.IN_WORDS(512), .OUT_WORDS(512)) dut (
    .pl_clk0     (clk),
    .pl_resetn0  (rst_n),
    .bus_addr    (addr),
    .bus_wr_en   (wr_en),
    .bus_wr_data (wr_data),
    .bus_rd_en   (rd_en),
    .bus_rd_data (rd_data),
    .bus_rd_valid(rd_valid),
    .bus_resp    (resp)
  );

  task automatic bus_write(input logic [16:0] a, input logic [31:0] d, output logic r);
    @(negedge clk);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; r = resp;
  endtask

  task automatic bus_read(input logic [16:0] a, output logic [31:0] d, output logic r, output logic v);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; d = rd_data; r = resp; v = rd_valid;
  endtask

  // lat = cycles from the start-write edge to the edge that raised TV_OUT_READY; 9999 on timeout
  task automatic wait_ready(output int lat);
    lat = 9999;
    @(negedge clk);
    addr = 17'h10010; rd_en = 1'b1;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      if (rd_data == 32'd1) begin
        lat = j;
        break;
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic start_task(input logic [7:0] t);
    logic r;
    bus_write(17'h10008, {24'd0, t}, r);
    bus_write(17'h1000C, 32'd1, r);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic r, v;
    rst_n = 1'b0; addr = 17'd0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || resp !== 1'b0 || rd_data !== 32'd0) begin
      failures++; $display("FAIL reset_outputs: got valid=%b resp=%b data=%h, want 0 0 0", rd_valid, resp, rd_data);
    end
    rst_n = 1'b1;
    bus_read(17'h10000, d, r, v);
    checks++;
    if (d !== 32'd1 || r !== 1'b0 || v !== 1'b1) begin
      failures++; $display("FAIL pl_ready: got data=%h resp=%b valid=%b, want 1 0 1", d, r, v);
    end
    bus_read(17'h10010, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL tv_out_reset: got %h want 0", d); end
    bus_read(17'h10004, d, r, v);
    checks++;
    if (d !== 32'h82 || r !== 1'b0) begin failures++; $display("FAIL enabled_tasks: got %h resp=%b want 82 0", d, r); end
    bus_read(17'h10008, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL task_reset: got %h want 0", d); end
    bus_read(17'h1000C, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL tv_in_reset: got %h want 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d; logic r, v;
    logic [16:0] ro_addr [5];
    logic [16:0] bad_addr [3];
    ro_addr  = '{17'h10000, 17'h10004, 17'h10010, 17'h00800, 17'h01000};
    bad_addr = '{17'h01000, 17'h1FFFC, 17'h10014};
    bus_write(17'h10008, 32'h0000_01AB, r);
    checks++;
    if (r !== 1'b0) begin failures++; $display("FAIL task_wr_resp: got %b want 0", r); end
    bus_read(17'h10008, d, r, v);
    checks++;
    if (d !== 32'hAB) begin failures++; $display("FAIL task_rd: got %h want ab", d); end
    bus_write(17'h1000C, 32'd0, r);
    checks++;
    if (r !== 1'b0) begin failures++; $display("FAIL tv_in_wr0_resp: got %b want 0", r); end
    bus_read(17'h1000C, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL tv_in_wr0_nostart: got %h want 0", d); end
    for (int i = 0; i < 5; i++) begin
      bus_write(ro_addr[i], 32'h1234_5678, r);
      checks++;
      if (r !== 1'b1) begin failures++; $display("FAIL ro_write_resp[%0d]: got %b want 1", i, r); end
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(bad_addr[i], d, r, v);
      checks++;
      if (d !== 32'd0 || r !== 1'b1 || v !== 1'b1) begin
        failures++; $display("FAIL unmapped_read[%0d]: got data=%h resp=%b valid=%b want 0 1 1", i, d, r, v);
      end
    end
    bus_write(17'h00004, 32'hCAFE_F00D, r);
    bus_read(17'h00007, d, r, v);
    checks++;
    if (d !== 32'hCAFE_F00D || r !== 1'b0) begin failures++; $display("FAIL in_buf_rw: got %h resp=%b want cafef00d 0", d, r); end
  endtask

  task automatic test_task1_max();
    logic [31:0] d; logic r, v; int lat; int bad; int ones;
    for (int i = 0; i < 250; i++) bus_write(17'(4 * i), (i == 100) ? 32'hFFFF_FFFF : 32'(i), r);
    start_task(8'd1);
    wait_ready(lat);
    checks++;
    if (lat > 260) begin failures++; $display("FAIL t1_latency: got %0d want <=260", lat); end
    bad = 0; ones = 0;
    for (int i = 0; i < 250; i++) begin
      bus_read(17'(32'h800 + 4 * i), d, r, v);
      ones += $countones(d);
      if (d !== ((i == 100) ? 32'd1 : 32'd0)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL t1_max_words: got %0d wrong words want 0", bad); end
    checks++;
    if (ones != 1) begin failures++; $display("FAIL t1_max_popcount: got %0d want 1", ones); end
  endtask

  task automatic test_task7_sum();
    logic [31:0] d; logic r, v; int lat;
    for (int i = 0; i < 256; i++) bus_write(17'(4 * i), 32'(i), r);
    bus_write(17'h00400, 32'h5555_5555, r);
    start_task(8'd7);
    wait_ready(lat);
    checks++;
    if (lat > 266) begin failures++; $display("FAIL t7_latency: got %0d want <=266", lat); end
    bus_read(17'h00800, d, r, v);
    checks++;
    if (d !== 32'h0000_7F80) begin failures++; $display("FAIL t7_sum: got %h want 7f80", d); end
    bus_read(17'h00990, d, r, v);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL t7_out100_kept: got %h want 1", d); end
    bus_read(17'h00804, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL t7_out1_kept: got %h want 0", d); end
  endtask

  task automatic test_busy();
    logic [31:0] d; logic r, v; int lat;
    start_task(8'd7);
    bus_write(17'h00014, 32'h0000_1234, r);
    checks++;
    if (r !== 1'b1) begin failures++; $display("FAIL busy_in_wr_resp: got %b want 1", r); end
    bus_write(17'h10008, 32'd1, r);
    checks++;
    if (r !== 1'b1) begin failures++; $display("FAIL busy_task_wr_resp: got %b want 1", r); end
    bus_write(17'h1000C, 32'd1, r);
    checks++;
    if (r !== 1'b0) begin failures++; $display("FAIL busy_tv_in_wr_resp: got %b want 0", r); end
    bus_read(17'h1000C, d, r, v);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL busy_tv_in: got %h want 1", d); end
    bus_read(17'h00990, d, r, v);
    checks++;
    if (d !== 32'd1 || r !== 1'b0) begin failures++; $display("FAIL busy_out_read: got %h resp=%b want 1 0", d, r); end
    wait_ready(lat);
    checks++;
    if (lat == 9999) begin failures++; $display("FAIL busy_run_done: got timeout want completion"); end
    bus_read(17'h00014, d, r, v);
    checks++;
    if (d !== 32'd5) begin failures++; $display("FAIL busy_in_unchanged: got %h want 5", d); end
    bus_read(17'h10008, d, r, v);
    checks++;
    if (d !== 32'd7) begin failures++; $display("FAIL busy_task_unchanged: got %h want 7", d); end
    bus_read(17'h1000C, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL tv_in_after_done: got %h want 0", d); end
    bus_read(17'h00800, d, r, v);
    checks++;
    if (d !== 32'h0000_7F80) begin failures++; $display("FAIL busy_t7_sum: got %h want 7f80", d); end
  endtask

  task automatic test_task1_tie();
    logic [31:0] d; logic r, v; int lat; int bad; int ones;
    for (int i = 0; i < 250; i++) bus_write(17'(4 * i), 32'd5, r);
    start_task(8'd1);
    wait_ready(lat);
    checks++;
    if (lat > 260) begin failures++; $display("FAIL tie_latency: got %0d want <=260", lat); end
    bad = 0; ones = 0;
    for (int i = 0; i < 250; i++) begin
      bus_read(17'(32'h800 + 4 * i), d, r, v);
      ones += $countones(d);
      if (d !== ((i == 0) ? 32'd1 : 32'd0)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL tie_words: got %0d wrong words want 0", bad); end
    checks++;
    if (ones != 1) begin failures++; $display("FAIL tie_popcount: got %0d want 1", ones); end
  endtask

  task automatic test_task7_ones();
    logic [31:0] d; logic r, v; int lat;
    for (int i = 0; i < 256; i++) bus_write(17'(4 * i), 32'hFFFF_FFFF, r);
    start_task(8'd7);
    wait_ready(lat);
    bus_read(17'h00800, d, r, v);
    checks++;
    if (d !== 32'hFFFF_FF00) begin failures++; $display("FAIL t7_ones_sum: got %h want ffffff00", d); end
    bus_read(17'h00804, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL t7_ones_out1: got %h want 0", d); end
  endtask

  task automatic test_unsupported();
    logic [31:0] d; logic r, v; int lat;
    start_task(8'd4);
    wait_ready(lat);
    checks++;
    if (lat > 4) begin failures++; $display("FAIL unsup_latency: got %0d want <=4", lat); end
    bus_read(17'h00800, d, r, v);
    checks++;
    if (d !== 32'hFFFF_FF00) begin failures++; $display("FAIL unsup_out0: got %h want ffffff00", d); end
    bus_read(17'h00804, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL unsup_out1: got %h want 0", d); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d; logic r, v; int lat;
    start_task(8'd1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(17'h1000C, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL midrun_tv_in: got %h want 0", d); end
    bus_read(17'h10010, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL midrun_tv_out: got %h want 0", d); end
    bus_read(17'h10000, d, r, v);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL midrun_pl_ready: got %h want 1", d); end
    bus_read(17'h10008, d, r, v);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL midrun_task: got %h want 0", d); end
    for (int i = 0; i < 256; i++) bus_write(17'(4 * i), 32'(i), r);
    start_task(8'd7);
    wait_ready(lat);
    checks++;
    if (lat > 266) begin failures++; $display("FAIL midrun_t7_latency: got %0d want <=266", lat); end
    bus_read(17'h00800, d, r, v);
    checks++;
    if (d !== 32'h0000_7F80) begin failures++; $display("FAIL midrun_t7_sum: got %h want 7f80", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_task1_max();
    test_task7_sum();
    test_busy();
    test_task1_tie();
    test_task7_ones();
    test_unsupported();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
